life_sequencer: RTL and testbench

LIFE_SEQUENCER -- requirements
Module: life_sequencer

---
 rtl/life_sequencer.sv | 144 ++++++++++++++
 tb/tb_life_sequencer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/life_sequencer.sv
// Sequencer for a 4x4 Game-of-Life array: clears, loads a pattern, runs up to
// gens generations and classifies the result. Define LIFE_SEQUENCER_OSC_DETECT_EN for period-2 detection.
module life_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic [15:0] pattern,
    input  logic [7:0]  gens,
    input  logic [15:0] alive,
    output logic        arr_reset,
    output logic [1:0]  arr_row,
    output logic [1:0]  arr_col,
    output logic        arr_val,
    output logic        arr_write_enb,
    output logic        arr_run,
    output logic        busy,
    output logic        done,
    output logic [1:0]  status,
    output logic [7:0]  gen_count
);

    typedef enum logic [2:0] {IDLE, CLEAR, LOAD, SETTLE, RUN, DONE} state_t;

    state_t      state, state_nxt;
    logic [15:0] pat_q;
    logic [7:0]  gens_q;
    logic [3:0]  idx;
    logic [15:0] hist1;
    logic        hit_died, hit_stable, hit_osc;
    logic        run_exit;
    logic [1:0]  status_hit;

`ifdef LIFE_SEQUENCER_OSC_DETECT_EN
    logic [15:0] hist2;
    assign hit_osc = (gen_count >= 8'd2) && (alive == hist2);
`else
    assign hit_osc = 1'b0;
`endif

    assign hit_died   = (alive == 16'h0000);
    assign hit_stable = (gen_count >= 8'd1) && (alive == hist1);
    assign run_exit   = hit_died || hit_stable || hit_osc || (gen_count == gens_q);

    // Priority: died, then stable, then oscillator; no hit means limit reached.
    always_comb begin
        status_hit = 2'b00;
        if (hit_died)        status_hit = 2'b01;
        else if (hit_stable) status_hit = 2'b10;
        else if (hit_osc)    status_hit = 2'b11;
    end

    always_comb begin
        state_nxt     = state;
        arr_reset     = 1'b0;
        arr_row       = 2'b00;
        arr_col       = 2'b00;
        arr_val       = 1'b0;
        arr_write_enb = 1'b0;
        arr_run       = 1'b0;
        done          = 1'b0;
        busy          = (state != IDLE);
        case (state)
            IDLE:   if (start && !abort) state_nxt = CLEAR;
            CLEAR: begin
                arr_reset = 1'b1;
                state_nxt = LOAD;
            end
            LOAD: begin
                arr_write_enb = 1'b1;
                arr_row       = idx[3:2];
                arr_col       = idx[1:0];
                arr_val       = pat_q[idx];
                if (idx == 4'd15) state_nxt = SETTLE;
            end
            SETTLE: state_nxt = RUN;
            RUN: begin
                // Exit cycle keeps arr_run low so the grid freezes on the evaluated generation.
                if (run_exit) state_nxt = DONE;
                else          arr_run   = 1'b1;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (abort && state != IDLE) begin
            state_nxt     = IDLE;
            arr_reset     = 1'b0;
            arr_write_enb = 1'b0;
            arr_run       = 1'b0;
            done          = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            pat_q     <= '0;
            gens_q    <= '0;
            idx       <= '0;
            hist1     <= '0;
`ifdef LIFE_SEQUENCER_OSC_DETECT_EN
            hist2     <= '0;
`endif
            status    <= 2'b00;
            gen_count <= '0;
        end else begin
            state <= state_nxt;
            if (abort && state != IDLE) begin
                status <= 2'b00;
            end else begin
                case (state)
                    IDLE: if (start && !abort) begin
                        pat_q     <= pattern;
                        gens_q    <= gens;
                        gen_count <= '0;
                        status    <= 2'b00;
                        idx       <= '0;
                        hist1     <= '0;
`ifdef LIFE_SEQUENCER_OSC_DETECT_EN
                        hist2     <= '0;
`endif
                    end
                    LOAD: idx <= idx + 4'd1;
                    RUN: begin
                        if (run_exit) begin
                            status <= status_hit;
                        end else begin
                            gen_count <= gen_count + 8'd1;
                            hist1     <= alive;
`ifdef LIFE_SEQUENCER_OSC_DETECT_EN
                            hist2     <= hist1;
`endif
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_life_sequencer.sv
// Bench for life_sequencer: a behavioural 4x4 life array feeds alive, and a
// scoreboard of expected outcomes is checked at each done pulse.
module tb_life_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] pattern = 16'h0000;
    logic [7:0]  gens = 8'd0;
    logic [15:0] alive;
    logic        arr_reset, arr_val, arr_write_enb, arr_run, busy, done;
    logic [1:0]  arr_row, arr_col, status;
    logic [7:0]  gen_count;

    int passed = 0;
    int total  = 0;
    int run_hi = 0;
    int done_cnt = 0;

    typedef struct {
        logic [1:0]  st;
        logic [7:0]  gc;
        logic [15:0] al;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    life_sequencer dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .pattern(pattern), .gens(gens), .alive(alive),
        .arr_reset(arr_reset), .arr_row(arr_row), .arr_col(arr_col),
        .arr_val(arr_val), .arr_write_enb(arr_write_enb), .arr_run(arr_run),
        .busy(busy), .done(done), .status(status), .gen_count(gen_count)
    );

    always #5 clk = ~clk;

    // Reference life array: dead cells beyond the 4x4 edge.
    logic [15:0] grid = 16'hbeef;
    assign alive = grid;

    function automatic logic [15:0] life_next(input logic [15:0] g);
        logic [15:0] nx;
        nx = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                int n;
                n = 0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        if (!(dr == 0 && dc == 0) && r + dr >= 0 && r + dr < 4 &&
                            c + dc >= 0 && c + dc < 4 && g[(r + dr) * 4 + c + dc])
                            n++;
                nx[r * 4 + c] = g[r * 4 + c] ? (n == 2 || n == 3) : (n == 3);
            end
        end
        return nx;
    endfunction

    always @(posedge clk) begin
        if (arr_reset)          grid <= 16'h0000;
        else if (arr_write_enb) grid[{arr_row, arr_col}] <= arr_val;
        else if (arr_run)       grid <= life_next(grid);
    end

    always @(negedge clk) begin
        if (arr_run) run_hi++;
        if (done)    done_cnt++;
    end

    task automatic run_op(input logic [15:0] p, input logic [7:0] g, input logic [1:0] st,
                          input logic [7:0] gc, input logic [15:0] al, input int cyc,
                          input string name);
        exp_t e;
        int   k;
        bit   got;
        e.st = st; e.gc = gc; e.al = al; e.cyc = cyc;
        sb.push_back(e);
        @(negedge clk);
        pattern = p; gens = g; start = 1'b1;
        k = 0; got = 0;
        while (k < 400 && !got) begin
            @(posedge clk); #1;
            start = 1'b0;
            k++;
            if (done) got = 1;
        end
        e = sb.pop_front();
        total++;
        if (!got) $display("FAIL %s_timeout: no done after %0d cycles", name, k);
        else begin
            passed++;
            total++;
            if (status !== e.st) $display("FAIL %s_status: got %b want %b", name, status, e.st);
            else passed++;
            total++;
            if (gen_count !== e.gc) $display("FAIL %s_gen_count: got %0d want %0d", name, gen_count, e.gc);
            else passed++;
            total++;
            if (alive !== e.al) $display("FAIL %s_alive: got %h want %h", name, alive, e.al);
            else passed++;
            if (e.cyc >= 0) begin
                total++;
                if (k != e.cyc) $display("FAIL %s_latency: got %0d want %0d", name, k, e.cyc);
                else passed++;
            end
            @(posedge clk); #1;
            total++;
            if (done !== 1'b0 || busy !== 1'b0 || status !== e.st || gen_count !== e.gc)
                $display("FAIL %s_after: done=%b busy=%b status=%b gc=%0d want 0 0 %b %0d",
                         name, done, busy, status, gen_count, e.st, e.gc);
            else passed++;
        end
    endtask

    task automatic test_reset();
        #1;
        total++;
        if ({arr_reset, arr_row, arr_col, arr_val, arr_write_enb, arr_run, busy, done, status, gen_count} !== '0)
            $display("FAIL reset_outputs: busy=%b done=%b status=%b gc=%0d arr_we=%b arr_run=%b want all 0",
                     busy, done, status, gen_count, arr_write_enb, arr_run);
        else passed++;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_died();
        run_op(16'h0001, 8'd10, 2'b01, 8'd1, 16'h0000, 21, "died");
    endtask

    task automatic test_stable();
        run_op(16'h0660, 8'd10, 2'b10, 8'd1, 16'h0660, 21, "stable");
    endtask

    task automatic test_blinker();
`ifdef LIFE_SEQUENCER_OSC_DETECT_EN
        run_op(16'h0222, 8'd10, 2'b11, 8'd2, 16'h0222, 22, "blinker");
`else
        run_op(16'h0222, 8'd10, 2'b00, 8'd10, 16'h0222, 30, "blinker");
`endif
    endtask

    task automatic test_limit();
        run_op(16'h0222, 8'd1, 2'b00, 8'd1, 16'h0070, 21, "limit1");
    endtask

    task automatic test_empty();
        int r0;
        r0 = run_hi;
        run_op(16'h0000, 8'd5, 2'b01, 8'd0, 16'h0000, 20, "empty");
        total++;
        if (run_hi != r0) $display("FAIL empty_arr_run: got %0d run cycles want 0", run_hi - r0);
        else passed++;
    endtask

    task automatic test_gens_zero();
        int r0;
        r0 = run_hi;
        run_op(16'h0660, 8'd0, 2'b00, 8'd0, 16'h0660, 20, "gens0");
        total++;
        if (run_hi != r0) $display("FAIL gens0_arr_run: got %0d run cycles want 0", run_hi - r0);
        else passed++;
    endtask

    task automatic test_abort();
        int d0;
        @(negedge clk);
        pattern = 16'h0f0f; gens = 8'd10; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) begin @(posedge clk); #1; end
        total++;
        if (arr_write_enb !== 1'b1 || arr_row !== 2'd1 || arr_col !== 2'd3 || arr_val !== 1'b0)
            $display("FAIL abort_load_idx7: we=%b row=%0d col=%0d val=%b want 1 1 3 0",
                     arr_write_enb, arr_row, arr_col, arr_val);
        else passed++;
        d0 = done_cnt;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || status !== 2'b00 || arr_write_enb !== 1'b0 || arr_run !== 1'b0)
            $display("FAIL abort_idle: busy=%b done=%b status=%b we=%b run=%b want all 0",
                     busy, done, status, arr_write_enb, arr_run);
        else passed++;
        run_op(16'h0660, 8'd10, 2'b10, 8'd1, 16'h0660, 21, "abort_restart");
        total++;
        if (done_cnt != d0 + 1) $display("FAIL abort_done_pulses: got %0d want 1", done_cnt - d0);
        else passed++;
    endtask

    task automatic test_start_abort_idle();
        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        total++;
        if (busy !== 1'b0) $display("FAIL start_abort_idle: busy=%b want 0", busy);
        else passed++;
    endtask

    task automatic test_back_to_back();
        fork
            run_op(16'h0660, 8'd10, 2'b10, 8'd1, 16'h0660, 21, "busy_start");
            begin
                repeat (10) @(negedge clk);
                start = 1'b1; pattern = 16'h0001; gens = 8'd3;
                @(negedge clk);
                start = 1'b0;
            end
        join
        run_op(16'h0001, 8'd10, 2'b01, 8'd1, 16'h0000, 21, "b2b_died");
    endtask

    task automatic test_reset_mid();
        int d0;
        d0 = done_cnt;
        @(negedge clk);
        pattern = 16'h0222; gens = 8'd10; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (22) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || status !== 2'b00 || gen_count !== 8'd0 || arr_run !== 1'b0)
            $display("FAIL reset_mid: busy=%b done=%b status=%b gc=%0d run=%b want all 0",
                     busy, done, status, gen_count, arr_run);
        else passed++;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (done_cnt != d0) $display("FAIL reset_mid_done: got %0d pulses want 0", done_cnt - d0);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_died();
        test_stable();
        test_blinker();
        test_limit();
        test_empty();
        test_gens_zero();
        test_abort();
        test_start_abort_idle();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
